// File: rtl/ujtag_dr_bridge.sv
// User data register bridge: samples UJTAG strobes in the fabric clock domain
// and exposes a capture/update interface around one WIDTH-bit LSB-first register.
`timescale 1ns/1ps
module ujtag_dr_bridge #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [7:0]  IR_CODE = 8'h10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       UIREG,
    input  logic             URSTB,
    input  logic             UDRCK,
    input  logic             UDRCAP,
    input  logic             UDRSH,
    input  logic             UDRUPD,
    input  logic             UTDI,
    output logic             UTDO,
    input  logic [WIDTH-1:0] cap_data,
    output logic             cap_ack,
    output logic [WIDTH-1:0] upd_data,
    output logic             upd_valid,
    output logic             selected
);

    logic [7:0]       uireg_s1_q, uireg_s2_q;
    logic             urstb_s1_q, urstb_s2_q;
    logic             ck_s1_q, ck_s2_q, ck_s3_q;
    logic             cap_s1_q, cap_s2_q, cap_s3_q;
    logic             sh_s1_q, sh_s2_q, sh_s3_q;
    logic             upd_s1_q, upd_s2_q, upd_s3_q;
    logic             tdi_s1_q, tdi_s2_q, tdi_s3_q;

    logic             selected_q, selected_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] upd_data_q, upd_data_d;
    logic             cap_ack_q, cap_ack_d;
    logic             upd_valid_q, upd_valid_d;

    logic             rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            uireg_s1_q <= '0;
            uireg_s2_q <= '0;
            urstb_s1_q <= 1'b0;
            urstb_s2_q <= 1'b0;
            ck_s1_q    <= 1'b0;
            ck_s2_q    <= 1'b0;
            ck_s3_q    <= 1'b0;
            cap_s1_q   <= 1'b0;
            cap_s2_q   <= 1'b0;
            cap_s3_q   <= 1'b0;
            sh_s1_q    <= 1'b0;
            sh_s2_q    <= 1'b0;
            sh_s3_q    <= 1'b0;
            upd_s1_q   <= 1'b0;
            upd_s2_q   <= 1'b0;
            upd_s3_q   <= 1'b0;
            tdi_s1_q   <= 1'b0;
            tdi_s2_q   <= 1'b0;
            tdi_s3_q   <= 1'b0;
        end else begin
            uireg_s1_q <= UIREG;
            uireg_s2_q <= uireg_s1_q;
            urstb_s1_q <= URSTB;
            urstb_s2_q <= urstb_s1_q;
            ck_s1_q    <= UDRCK;
            ck_s2_q    <= ck_s1_q;
            ck_s3_q    <= ck_s2_q;
            cap_s1_q   <= UDRCAP;
            cap_s2_q   <= cap_s1_q;
            cap_s3_q   <= cap_s2_q;
            sh_s1_q    <= UDRSH;
            sh_s2_q    <= sh_s1_q;
            sh_s3_q    <= sh_s2_q;
            upd_s1_q   <= UDRUPD;
            upd_s2_q   <= upd_s1_q;
            upd_s3_q   <= upd_s2_q;
            tdi_s1_q   <= UTDI;
            tdi_s2_q   <= tdi_s1_q;
            tdi_s3_q   <= tdi_s2_q;
        end
    end

    // Control bits are taken from s3 so they line up with the sample just before the TCK edge.
    assign rise = ck_s2_q & ~ck_s3_q;
    assign fall = ~ck_s2_q & ck_s3_q;

    always_comb begin
        selected_d  = (uireg_s2_q == IR_CODE) && urstb_s2_q;
        sr_d        = sr_q;
        cap_ack_d   = 1'b0;
        upd_data_d  = upd_data_q;
        upd_valid_d = 1'b0;
        if (!urstb_s2_q) begin
            sr_d = '0;
        end else if (rise && selected_q) begin
            if (cap_s3_q) begin
                sr_d      = cap_data;
                cap_ack_d = 1'b1;
            end else if (sh_s3_q) begin
                sr_d = {tdi_s3_q, sr_q[WIDTH-1:1]};
            end
        end
        if (fall && selected_q && upd_s3_q) begin
            upd_data_d  = sr_q;
            upd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selected_q  <= 1'b0;
            sr_q        <= '0;
            cap_ack_q   <= 1'b0;
            upd_data_q  <= '0;
            upd_valid_q <= 1'b0;
        end else begin
            selected_q  <= selected_d;
            sr_q        <= sr_d;
            cap_ack_q   <= cap_ack_d;
            upd_data_q  <= upd_data_d;
            upd_valid_q <= upd_valid_d;
        end
    end

    assign UTDO      = sr_q[0] & selected_q;
    assign cap_ack   = cap_ack_q;
    assign upd_data  = upd_data_q;
    assign upd_valid = upd_valid_q;
    assign selected  = selected_q;

endmodule

// File: tb/tb_ujtag_dr_bridge.sv
// Self-checking bench for ujtag_dr_bridge: table of scans plus hand-written
// TAP-reset and fabric-reset sequences, update words checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_ujtag_dr_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  UIREG;
    logic        URSTB, UDRCK, UDRCAP, UDRSH, UDRUPD, UTDI;
    logic        UTDO;
    logic [31:0] cap_data;
    logic        cap_ack;
    logic [31:0] upd_data;
    logic        upd_valid;
    logic        selected;

    int          checks = 0;
    int          errors = 0;
    int          cap_cnt = 0;
    int          upd_cnt = 0;
    bit          mon_en = 1'b0;
    logic        rst_seen;
    logic        cap_prev = 1'b0;
    logic        updv_prev = 1'b0;
    logic [31:0] upd_prev = '0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  ir;
        logic [31:0] cap;
        logic [31:0] word;
        int unsigned nbits;
        logic [31:0] exp_tdo;
        logic [31:0] exp_upd;
        bit          sel;
    } vec_t;

    vec_t vecs[5];

    ujtag_dr_bridge #(.WIDTH(32), .IR_CODE(8'h10)) dut (
        .clk       (clk),
        .rst       (rst),
        .UIREG     (UIREG),
        .URSTB     (URSTB),
        .UDRCK     (UDRCK),
        .UDRCAP    (UDRCAP),
        .UDRSH     (UDRSH),
        .UDRUPD    (UDRUPD),
        .UTDI      (UTDI),
        .UTDO      (UTDO),
        .cap_data  (cap_data),
        .cap_ack   (cap_ack),
        .upd_data  (upd_data),
        .upd_valid (upd_valid),
        .selected  (selected)
    );

    always #10 clk = ~clk;

    always @(posedge clk) rst_seen <= rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cap_ack) begin
                cap_cnt++;
                chk("cap_ack_width", {31'd0, cap_prev}, 32'd0);
            end
            if (upd_valid) begin
                upd_cnt++;
                chk("upd_valid_width", {31'd0, updv_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected actual=%h expected=none", upd_data);
                end else begin
                    chk("upd_word", upd_data, exp_q.pop_front());
                end
            end else if (!rst_seen) begin
                chk("upd_hold", upd_data, upd_prev);
            end
        end
        cap_prev  = cap_ack;
        updv_prev = upd_valid;
        upd_prev  = upd_data;
    end

    task automatic tck(input logic cap, input logic sh, input logic upd, input logic tdi);
        UDRCAP = cap;
        UDRSH  = sh;
        UDRUPD = upd;
        UTDI   = tdi;
        #100 UDRCK = 1'b1;
        #100 UDRCK = 1'b0;
    endtask

    task automatic scan(input logic [7:0] ir, input logic [31:0] cap, input logic [31:0] word,
                        input int unsigned nbits, input bit do_upd, output logic [31:0] tdo_w);
        UIREG    = ir;
        cap_data = cap;
        #200;
        tck(1'b1, 1'b0, 1'b0, 1'b0);
        tdo_w = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            tdo_w[i] = UTDO;
            tck(1'b0, 1'b1, 1'b0, word[i]);
        end
        if (do_upd) tck(1'b0, 1'b0, 1'b1, 1'b0);
        tck(1'b0, 1'b0, 1'b0, 1'b0);
        #200;
    endtask

    initial begin
        logic [31:0] tdo_w;
        int          c0, u0;

        vecs[0] = '{8'h10, 32'hDEADBEEF, 32'hA5A51234, 32, 32'hDEADBEEF, 32'hA5A51234, 1'b1};
        vecs[1] = '{8'h11, 32'hDEADBEEF, 32'hA5A51234, 32, 32'h00000000, 32'hA5A51234, 1'b0};
        vecs[2] = '{8'h10, 32'h12345678, 32'hFFFFFFFF,  8, 32'h00000078, 32'hFF123456, 1'b1};
        vecs[3] = '{8'h10, 32'h00000000, 32'h00000001, 32, 32'h00000000, 32'h00000001, 1'b1};
        vecs[4] = '{8'h10, 32'h80000001, 32'h00000001,  1, 32'h00000001, 32'hC0000000, 1'b1};

        rst = 1'b1; UIREG = 8'h10; URSTB = 1'b1; UDRCK = 1'b0;
        UDRCAP = 1'b0; UDRSH = 1'b0; UDRUPD = 1'b0; UTDI = 1'b0; cap_data = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_utdo",      {31'd0, UTDO},      32'd0);
        chk("rst_cap_ack",   {31'd0, cap_ack},   32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_selected",  {31'd0, selected},  32'd0);
        chk("rst_upd_data",  upd_data,           32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sel_lag_2", {31'd0, selected}, 32'd0);
        @(negedge clk);
        chk("sel_lag_3", {31'd0, selected}, 32'd1);
        mon_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            c0 = cap_cnt;
            u0 = upd_cnt;
            if (vecs[v].sel) exp_q.push_back(vecs[v].exp_upd);
            scan(vecs[v].ir, vecs[v].cap, vecs[v].word, vecs[v].nbits, 1'b1, tdo_w);
            chk($sformatf("v%0d_tdo", v), tdo_w, vecs[v].exp_tdo);
            chk($sformatf("v%0d_cap_cnt", v), cap_cnt - c0, {31'd0, vecs[v].sel});
            chk($sformatf("v%0d_upd_cnt", v), upd_cnt - u0, {31'd0, vecs[v].sel});
            chk($sformatf("v%0d_upd_data", v), upd_data, vecs[v].exp_upd);
        end

        u0 = upd_cnt;
        scan(8'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 1'b0, tdo_w);
        chk("tapr_utdo_before", {31'd0, UTDO}, 32'd1);
        URSTB = 1'b0;
        #200;
        chk("tapr_selected", {31'd0, selected}, 32'd0);
        tck(1'b0, 1'b0, 1'b1, 1'b0);
        tck(1'b0, 1'b0, 1'b0, 1'b0);
        #200;
        chk("tapr_no_upd", upd_cnt - u0, 32'd0);
        chk("tapr_upd_data", upd_data, 32'hC0000000);
        URSTB = 1'b1;
        #200;
        chk("tapr_reselect", {31'd0, selected}, 32'd1);
        chk("tapr_sr_cleared", {31'd0, UTDO}, 32'd0);

        scan(8'h10, 32'hFFFFFFFF, 32'h00000000, 16, 1'b0, tdo_w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_upd_data", upd_data, 32'd0);
        chk("mrst_selected", {31'd0, selected}, 32'd0);
        chk("mrst_utdo", {31'd0, UTDO}, 32'd0);
        chk("mrst_flags", {30'd0, cap_ack, upd_valid}, 32'd0);
        #200;
        u0 = upd_cnt;
        exp_q.push_back(32'h0F0F0F0F);
        scan(8'h10, 32'h00000000, 32'h0F0F0F0F, 32, 1'b1, tdo_w);
        chk("mrst_rescan_cnt", upd_cnt - u0, 32'd1);
        chk("mrst_rescan_data", upd_data, 32'h0F0F0F0F);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
